// File: rtl/tr_pulse_timer_pkg.sv
// ============================================================================
// tr_pkg : shared state type and control/status bit indices for the TR timer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package tr_pkg;

    localparam int TR_CTRL_W = 4;
    localparam int TR_STAT_W = 4;

    // Bit positions are shared with the control-register slave.
    localparam int TR_CTRL_START = 0;
    localparam int TR_CTRL_STOP  = 1;
    localparam int TR_CTRL_MODE  = 2;
    localparam int TR_CTRL_CLEAR = 3;

    localparam int TR_STAT_BUSY  = 0;
    localparam int TR_STAT_DONE  = 1;
    localparam int TR_STAT_MODE  = 2;
    localparam int TR_STAT_WRAP  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tr_timer_state_t;

endpackage

`default_nettype wire

// File: rtl/tr_pulse_timer_if.sv
// ============================================================================
// tr_pulse_timer_if : control-word strobe and status return between the
// register slave (master side) and the pulse timer (slave side)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface tr_pulse_timer_if;

    logic                          ctrl_valid;
    logic [tr_pkg::TR_CTRL_W-1:0]  ctrl_data;
    logic [tr_pkg::TR_STAT_W-1:0]  status;

    modport master (
        output ctrl_valid,
        output ctrl_data,
        input  status
    );

    modport slave (
        input  ctrl_valid,
        input  ctrl_data,
        output status
    );

endinterface

`default_nettype wire

// File: rtl/tr_down_counter.sv
// ============================================================================
// tr_down_counter : loadable down-counter that saturates at zero
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tr_down_counter #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_val,
    input  wire logic             i_en,
    output logic                  o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/tr_pulse_timer.sv
// ============================================================================
// tr_pulse_timer : one-shot / continuous period timer with tick counter.
// Optional interrupt output enabled by defining TR_TIMER_IRQ_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tr_pulse_timer
    import tr_pkg::*;
#(
    parameter int PERIOD = 100,
    parameter int CNT_W  = 16,
    parameter int TCNT_W = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    tr_pulse_timer_if.slave     ctrl_if,
    output logic                tick,
    output logic [TCNT_W-1:0]   tick_cnt
`ifdef TR_TIMER_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(PERIOD - 1);

    tr_timer_state_t   r_state;
    tr_timer_state_t   w_state_nxt;

    logic              w_start;
    logic              w_stop;
    logic              w_clear;
    logic              w_zero;
    logic              w_busy;
    logic              w_expire;
    logic              w_load;
    logic              w_en;

    logic              r_done;
    logic              r_mode;
    logic              r_wrap;
    logic [TCNT_W-1:0] r_tick_cnt;

    // STOP masks START when both arrive in the same word.
    assign w_stop  = ctrl_if.ctrl_valid & ctrl_if.ctrl_data[TR_CTRL_STOP];
    assign w_start = ctrl_if.ctrl_valid & ctrl_if.ctrl_data[TR_CTRL_START]
                   & ~ctrl_if.ctrl_data[TR_CTRL_STOP];
    assign w_clear = ctrl_if.ctrl_valid & ctrl_if.ctrl_data[TR_CTRL_CLEAR];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_stop)                  w_state_nxt = IDLE;
                else if (w_start)            w_state_nxt = RUN;
                else if (w_zero && !r_mode)  w_state_nxt = DONE;
            end
            DONE: begin
                if (w_start)      w_state_nxt = RUN;
                else if (w_clear) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // An expiry coinciding with a restart or stop is swallowed.
    always_comb begin
        w_busy   = (r_state == RUN);
        w_expire = w_busy & w_zero & ~w_start & ~w_stop;
    end

    assign w_load = w_start | (w_expire & r_mode);
    assign w_en   = w_busy & ~w_stop;

    tr_down_counter #(
        .CNT_W (CNT_W)
    ) u_down_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (c_RELOAD),
        .i_en       (w_en),
        .o_zero     (w_zero)
    );

    // CLEAR dominates anything recorded in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done     <= 1'b0;
            r_mode     <= 1'b0;
            r_wrap     <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            if (w_start) r_mode <= ctrl_if.ctrl_data[TR_CTRL_MODE];

            if (w_clear || w_start)       r_done <= 1'b0;
            else if (w_expire && !r_mode) r_done <= 1'b1;

            if (w_clear) begin
                r_tick_cnt <= '0;
                r_wrap     <= 1'b0;
            end else if (w_expire) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
                if (&r_tick_cnt) r_wrap <= 1'b1;
            end
        end
    end

`ifdef TR_TIMER_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else if (w_clear) begin
            r_irq <= 1'b0;
        end else if (w_expire) begin
            r_irq <= 1'b1;
        end
    end

    assign irq = r_irq;
`endif

    assign tick     = w_expire;
    assign tick_cnt = r_tick_cnt;

    assign ctrl_if.status[TR_STAT_BUSY] = w_busy;
    assign ctrl_if.status[TR_STAT_DONE] = r_done;
    assign ctrl_if.status[TR_STAT_MODE] = r_mode;
    assign ctrl_if.status[TR_STAT_WRAP] = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_tr_pulse_timer.sv
// ============================================================================
// tb_tr_pulse_timer : two timer instances (PERIOD=4 and PERIOD=1) checked
// against an event-time reference model plus directed sequences
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tr_pulse_timer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tr_pulse_timer_if if_a ();
    tr_pulse_timer_if if_b ();

    logic       tick_a, tick_b;
    logic [7:0] cnt_a, cnt_b;
`ifdef TR_TIMER_IRQ_EN
    logic       irq_a, irq_b;
`endif

    tr_pulse_timer #(.PERIOD(4), .CNT_W(16), .TCNT_W(8)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .ctrl_if  (if_a.slave),
        .tick     (tick_a),
        .tick_cnt (cnt_a)
`ifdef TR_TIMER_IRQ_EN
        ,
        .irq      (irq_a)
`endif
    );

    tr_pulse_timer #(.PERIOD(1), .CNT_W(16), .TCNT_W(8)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .ctrl_if  (if_b.slave),
        .tick     (tick_b),
        .tick_cnt (cnt_b)
`ifdef TR_TIMER_IRQ_EN
        ,
        .irq      (irq_b)
`endif
    );

    // Reference model: the next tick is an absolute cycle number, the tick
    // count is the plain total since CLEAR; wrap means the total passed 255.
    typedef struct {
        bit run;
        bit done;
        bit mode;
        bit irq;
        int nxt;
        int total;
    } model_t;

    typedef struct {
        bit         v;
        logic [3:0] d;
        bit         et;
        logic [3:0] es;
        logic [7:0] ec;
    } vec_t;

    model_t     m [2];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic       s_tick [2];
    logic [3:0] s_stat [2];
    logic [7:0] s_cnt  [2];
    logic       s_irq  [2];

    function automatic int per_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m[k].run = 0; m[k].done = 0; m[k].mode = 0;
            m[k].irq = 0; m[k].nxt = 0;  m[k].total = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_expect(input int k, input bit v, input logic [3:0] d,
                                output bit et, output logic [3:0] es,
                                output logic [7:0] ec, output bit ei);
        et = m[k].run && (cyc == m[k].nxt) && !(v && (d[0] || d[1]));
        es = {(m[k].total >= 256), m[k].mode, m[k].done, m[k].run};
        ec = 8'(m[k].total % 256);
        ei = m[k].irq;
    endtask

    task automatic model_update(input int k, input bit v, input logic [3:0] d, input bit t);
        if (t) begin
            m[k].total++;
            m[k].irq = 1;
            if (m[k].mode) m[k].nxt = m[k].nxt + per_of(k);
            else begin m[k].run = 0; m[k].done = 1; end
        end
        if (v && d[3]) begin
            m[k].total = 0; m[k].done = 0; m[k].irq = 0;
        end
        if (v && d[1]) begin
            m[k].run = 0;
        end else if (v && d[0]) begin
            m[k].run  = 1;
            m[k].nxt  = cyc + per_of(k);
            m[k].mode = d[2];
            m[k].done = 0;
        end
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic step(input bit va, input logic [3:0] da, input bit vb, input logic [3:0] db);
        bit         v [2];
        logic [3:0] d [2];
        bit         et, ei;
        logic [3:0] es;
        logic [7:0] ec;
        v[0] = va; d[0] = da; v[1] = vb; d[1] = db;
        if_a.ctrl_valid = va; if_a.ctrl_data = da;
        if_b.ctrl_valid = vb; if_b.ctrl_data = db;
        @(negedge clk);
        s_tick[0] = tick_a; s_stat[0] = if_a.status; s_cnt[0] = cnt_a;
        s_tick[1] = tick_b; s_stat[1] = if_b.status; s_cnt[1] = cnt_b;
`ifdef TR_TIMER_IRQ_EN
        s_irq[0] = irq_a; s_irq[1] = irq_b;
`else
        s_irq[0] = 1'b0;  s_irq[1] = 1'b0;
`endif
        for (int k = 0; k < 2; k++) begin
            model_expect(k, v[k], d[k], et, es, ec, ei);
            check((k == 0) ? "model_tick_a"   : "model_tick_b",   32'(s_tick[k]), 32'(et));
            check((k == 0) ? "model_status_a" : "model_status_b", 32'(s_stat[k]), 32'(es));
            check((k == 0) ? "model_cnt_a"    : "model_cnt_b",    32'(s_cnt[k]),  32'(ec));
`ifdef TR_TIMER_IRQ_EN
            check((k == 0) ? "model_irq_a"    : "model_irq_b",    32'(s_irq[k]),  32'(ei));
`endif
            model_update(k, v[k], d[k], et);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset_async();
        #1 rst = 1'b0;
        #1;
        check("async_rst_tick_a",   32'(tick_a),      32'd0);
        check("async_rst_tick_b",   32'(tick_b),      32'd0);
        check("async_rst_status_a", 32'(if_a.status), 32'd0);
        check("async_rst_status_b", 32'(if_b.status), 32'd0);
        check("async_rst_cnt_a",    32'(cnt_a),       32'd0);
        check("async_rst_cnt_b",    32'(cnt_b),       32'd0);
        if_a.ctrl_valid = 1'b0; if_b.ctrl_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc = cyc + 2;
        model_clear();
    endtask

    vec_t tab [18];

    initial begin
        int n;
        int first;
        logic [3:0] ra, rb;
        bit va, vb;

        for (int i = 0; i < 18; i++) begin
            tab[i].v  = (i == 10);
            tab[i].d  = (i == 10) ? 4'b0001 : 4'b0000;
            tab[i].et = (i == 14);
            tab[i].es = (i >= 15) ? 4'b0010 : ((i >= 11) ? 4'b0001 : 4'b0000);
            tab[i].ec = (i >= 15) ? 8'd1 : 8'd0;
        end

        if_a.ctrl_valid = 1'b0; if_a.ctrl_data = '0;
        if_b.ctrl_valid = 1'b0; if_b.ctrl_data = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // One-shot from reset.
        for (int i = 0; i < 18; i++) begin
            step(tab[i].v, tab[i].d, 1'b0, 4'b0000);
            check("tab_tick",   32'(s_tick[0]), 32'(tab[i].et));
            check("tab_status", 32'(s_stat[0]), 32'(tab[i].es));
            check("tab_cnt",    32'(s_cnt[0]),  32'(tab[i].ec));
        end
`ifdef TR_TIMER_IRQ_EN
        check("irq_after_oneshot", 32'(s_irq[0]), 32'd1);
`endif

        // Continuous, then STOP at offset 10 suppresses the tick at 12.
        n = 0;
        for (int i = 0; i < 15; i++) begin
            step((i == 0) || (i == 10), (i == 0) ? 4'b0101 : 4'b0010, 1'b0, 4'b0000);
            if (s_tick[0]) n++;
        end
        check("cont_tick_count", 32'(n), 32'd2);
        check("stop_status",     32'(s_stat[0]), 32'b0100);
        check("cont_cnt",        32'(s_cnt[0]),  32'd3);
`ifdef TR_TIMER_IRQ_EN
        check("irq_held_over_start", 32'(s_irq[0]), 32'd1);
`endif
        step(1'b1, 4'b1000, 1'b0, 4'b0000);
        step(1'b0, 4'b0000, 1'b0, 4'b0000);
        check("clear_cnt", 32'(s_cnt[0]), 32'd0);
`ifdef TR_TIMER_IRQ_EN
        check("clear_irq", 32'(s_irq[0]), 32'd0);
`endif

        // Restart two cycles into a run pushes the tick to offset 6.
        first = -1;
        for (int i = 0; i < 9; i++) begin
            step((i == 0) || (i == 2), 4'b0001, 1'b0, 4'b0000);
            if (s_tick[0] && (first < 0)) first = i;
        end
        check("restart_first_tick", 32'(first), 32'd6);

        // PERIOD=1 continuous wrap on B while A runs continuous.
        step(1'b1, 4'b0101, 1'b1, 4'b0101);
        for (int i = 0; i < 257; i++) step(1'b0, 4'b0000, 1'b0, 4'b0000);
        check("wrap_cnt",    32'(s_cnt[1]),  32'd0);
        check("wrap_status", 32'(s_stat[1]), 32'b1101);
        step(1'b0, 4'b0000, 1'b1, 4'b1000);
        step(1'b0, 4'b0000, 1'b0, 4'b0000);
        check("clear_wrap_cnt",  32'(s_cnt[1]),     32'd0);
        check("clear_wrap_flag", 32'(s_stat[1][3]), 32'd0);

        do_reset_async();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'b0000, 1'b0, 4'b0000);
            if (s_tick[0] || s_tick[1]) n++;
        end
        check("no_tick_after_reset", 32'(n), 32'd0);

        // START+STOP from IDLE does nothing.
        step(1'b1, 4'b0011, 1'b1, 4'b0111);
        step(1'b0, 4'b0000, 1'b0, 4'b0000);
        check("startstop_idle_a", 32'(s_stat[0]), 32'd0);
        check("startstop_idle_b", 32'(s_stat[1]), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            va = ($urandom_range(0, 4) == 0);
            vb = ($urandom_range(0, 4) == 0);
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) begin ra[1] = 1'b0; rb[1] = 1'b0; end
            if ($urandom_range(0, 2) != 0) begin ra[3] = 1'b0; rb[3] = 1'b0; end
            step(va, ra, vb, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tr_pulse_timer.md
# tr_pulse_timer

Control-driven period timer that sits directly downstream of the TR Avalon-MM control-register slave. It consumes the 4-bit control word each time the slave accepts a write. It runs a programmable down-counter in one-shot or continuous mode and emits single-cycle ticks. It returns a 4-bit status word that the slave presents on its read path.

## Interface
Parameters:
- `PERIOD`, 100: ticks are PERIOD cycles apart; legal range 1 .. 2^CNT_W.
- `CNT_W`, 16: down-counter width.
- `TCNT_W`, 8: width of the tick counter.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low (`rst`=0 resets), synchronous deassert supplied externally.
- `ctrl_valid`  in  1  one-cycle strobe; the slave's write was accepted this cycle.
- `ctrl_data`  in  4  control word:
  - [0] START
  - [1] STOP
  - [2] MODE (1 = continuous, 0 = one-shot)
  - [3] CLEAR
- `status`  out  4  status word:
  - [0] busy
  - [1] done
  - [2] mode latched
  - [3] tick-count wrapped (sticky)
- `tick`  out  1  single-cycle pulse at period expiry.
- `tick_cnt`  out  TCNT_W  number of ticks since last CLEAR, wraps.
- `irq`  out  1  present only with `TR_TIMER_IRQ_EN`.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, counter=0, `tick`=0, `tick_cnt`=0, `status`=4'b0000, `irq`=0.
- `ctrl_data` is sampled only when `ctrl_valid`=1. The word is not held by the block.
- MODE is latched into status[2] on every START.
- START in any state:
  - counter <= PERIOD-1, state <= RUN.
  - In RUN this is a restart; a pending expiry in that cycle is discarded and no tick is produced.
- STOP in RUN: state <= IDLE, counter frozen, no tick. STOP in IDLE/DONE: no effect.
- Simultaneous bits in one word: STOP overrides START.
- CLEAR:
  - Clears done, wrap flag, `tick_cnt` and `irq`.
  - In DONE, state <= IDLE.
  - CLEAR+START together: clear first, then start. Result is RUN with `tick_cnt`=0.
- RUN with counter≠0: decrement by 1 per cycle.
- RUN with counter==0 (expiry): `tick`=1 this cycle and `tick_cnt` increments.
  - Continuous: counter <= PERIOD-1, stay in RUN.
  - One-shot: state <= DONE, done <= 1.
- `tick_cnt` wraps from 2^TCNT_W-1 to 0 and sets status[3], which stays set until CLEAR.
- Status encoding:
  - busy = (state==RUN)
  - done is set on one-shot expiry and cleared by CLEAR or START.

## Timing
- `ctrl_valid` with START in cycle N: RUN and counter=PERIOD-1 from cycle N+1. First `tick` is in cycle N+PERIOD.
- Continuous mode: ticks every PERIOD cycles. With PERIOD=1, `tick` is high every cycle from N+1.
- `tick` is decoded from registered state and counter: high exactly one cycle per expiry, never two in a row except when PERIOD=1.
- `status`, `tick_cnt` and `irq` are registered. They reflect an event the cycle after it, e.g. done=1 in N+PERIOD+1.
- Reset asserted mid-run: all outputs return to reset values immediately, without waiting for a clock edge.

## Configuration
- `TR_TIMER_IRQ_EN` defined:
  - Port `irq` exists. It is set the cycle after any `tick` in which the previous `irq` was 0, and is held until CLEAR.
  - START does not clear `irq`.
- `TR_TIMER_IRQ_EN` undefined: no `irq` port and no irq register; all other behaviour is identical.

## Structure
- Shared package `tr_pkg`:
  - state enum `tr_timer_state_t` (IDLE, RUN, DONE).
  - control bit indices `TR_CTRL_START`=0, `TR_CTRL_STOP`=1, `TR_CTRL_MODE`=2, `TR_CTRL_CLEAR`=3.
  - status bit indices `TR_STAT_BUSY`..`TR_STAT_WRAP`.
  - These indices are shared with the control-register slave.
- One sub-module, `tr_down_counter`: loadable CNT_W down-counter with load, enable and zero flag. The FSM, tick counter and status logic live in the top.

## Test plan
- PERIOD=4, write 4'b0001 at cycle 10 -> `tick` only at cycle 14; status=4'b0010 from cycle 15; `tick_cnt`=1.
- PERIOD=4, write 4'b0101 -> ticks at 14, 18, 22…; busy stays 1. Write 4'b0010 at cycle 20 -> IDLE at 21, no tick at 22.
- Write 4'b0011 from IDLE -> stays IDLE, status=0. Write START at cycle 12 while RUN -> first tick moves to cycle 16.
- TCNT_W=8, continuous PERIOD=1, run 256 cycles -> `tick_cnt` wraps to 0 and status[3]=1. Write 4'b1000 -> `tick_cnt`=0, status[3]=0 next cycle.
- Assert `rst`=0 asynchronously mid-RUN between edges -> `tick`, `status` and `tick_cnt` read 0 before the next edge; after release, no tick without a new START.
- With `TR_TIMER_IRQ_EN`: one-shot expiry -> `irq`=1 next cycle, held through a further START. Write 4'b1000 -> `irq`=0.
